// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: lane modes, FSM states and beat arithmetic shared by the SPI lane master.
package spi_arb_pkg;
  typedef enum logic [1:0] {LANE1 = 2'b00, LANE2 = 2'b01, LANE4 = 2'b10} lane_mode_e;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, TAIL, GAP} state_e;
  function automatic int lanes_of(logic [1:0] mode);
    return mode == LANE2 ? 2 : mode == LANE4 ? 4 : 1;
  endfunction
  function automatic int beats_of(int len, logic [1:0] mode);
    return 8 * len / lanes_of(mode);
  endfunction
endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: round-robin grant starting after the last granted index.
module spi_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);
  logic [ID_W-1:0] last;
  logic found;
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= NUM_REQ; i++)
      if (!found && req[(int'(last) + i) % NUM_REQ]) begin
        found = 1'b1;
        idx = ID_W'((int'(last) + i) % NUM_REQ);
      end
  end
  assign grant = found ? NUM_REQ'(1) << idx : '0;
  always_ff @(posedge clk)
    if (rst) last <= ID_W'(NUM_REQ - 1);
    else if (advance) last <= idx;
endmodule

// File: rtl/spi_lane_master_arb.sv
// spi_lane_master_arb: shares a 1/2/4-lane mode-0 SPI port between round-robin requesters.
module spi_lane_master_arb
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_BYTES = 4,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP = 2,
  localparam int LEN_W = $clog2(MAX_BYTES + 1),
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [2*NUM_REQ-1:0]         req_lanes,
  input  logic [LEN_W*NUM_REQ-1:0]     req_len,
  input  logic [8*MAX_BYTES*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  output logic [ID_W-1:0]              rsp_id,
  output logic [8*MAX_BYTES-1:0]       rsp_data,
  output logic                         busy,
  output logic                         sclk,
  output logic                         cs_n,
  output logic [3:0]                   mosi,
  output logic [3:0]                   mosi_oe,
  input  logic [3:0]                   miso
);
  localparam int NB = 8 * MAX_BYTES;
  localparam int BW = $clog2(NB + 1);
  localparam int CW = $clog2((CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP) + 1);
  state_e state, next;
  logic [CW-1:0] cnt;
  logic [BW-1:0] beat, last_beat;
  logic [2:0] lw;
  logic [3:0] lane_oe;
  logic [NB-1:0] tx, rx, rx_nx, rsp_q;
  logic [ID_W-1:0] id, id_q, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0] sel_lanes;
  logic [LEN_W-1:0] sel_raw, sel_len;
  logic accept, done, active;
  int base;
  spi_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk(clk), .rst(rst), .req(req_valid), .advance(accept), .grant(gnt), .idx(gnt_idx)
  );
  assign sel_lanes = req_lanes[2*gnt_idx +: 2];
  assign sel_raw = req_len[LEN_W*gnt_idx +: LEN_W];
  assign sel_len = sel_raw > LEN_W'(MAX_BYTES) ? LEN_W'(MAX_BYTES) : sel_raw;
  assign accept = !rst && state == IDLE && |req_valid;
  assign done = cnt == '0;
  assign active = state inside {SETUP, HIGH, LOW, TAIL};
  assign req_ready = accept ? gnt : '0;
  assign rsp_valid = !rst && state == GAP && done;
  assign rsp_id = rsp_valid ? id : id_q;
  assign rsp_data = rsp_valid ? rx : rsp_q;
  assign busy = state != IDLE;
  assign sclk = state == HIGH;
  assign cs_n = !active;
  assign mosi_oe = active ? lane_oe : 4'b0;
  assign mosi = tx[3:0] & mosi_oe;
  assign base = int'(beat) * int'(lw);
  // Beat n lands MISO lane k at serial bit n*L+k.
  always_comb begin
    rx_nx = rx;
    for (int p = 0; p < NB; p++)
      if (p >= base && p < base + int'(lw)) rx_nx[p] = miso[2'(p - base)];
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = sel_len == '0 ? GAP : SETUP;
      SETUP:   if (done) next = HIGH;
      HIGH:    if (done) next = beat == last_beat ? TAIL : LOW;
      LOW:     if (done) next = HIGH;
      TAIL:    if (done) next = GAP;
      GAP:     if (done) next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      beat <= '0;
      last_beat <= '0;
      lw <= 3'd1;
      lane_oe <= '0;
      tx <= '0;
      rx <= '0;
      rsp_q <= '0;
      id <= '0;
      id_q <= '0;
    end else begin
      state <= next;
      cnt <= next != state ? (next == GAP ? CW'(CS_GAP - 1) : CW'(CLK_DIV - 1)) : cnt - 1'b1;
      if (accept) begin
        tx <= req_data[NB*gnt_idx +: NB];
        rx <= '0;
        id <= gnt_idx;
        lw <= 3'(lanes_of(sel_lanes));
        lane_oe <= 4'((1 << lanes_of(sel_lanes)) - 1);
        beat <= '0;
        last_beat <= BW'(beats_of(int'(sel_len), sel_lanes) - 1);
      end
      if (state == HIGH && done) begin
        rx <= rx_nx;
        beat <= beat + 1'b1;
        if (next == LOW) tx <= tx >> lw;
      end
      if (rsp_valid) begin
        rsp_q <= rx;
        id_q <= id;
      end
    end
  end
endmodule

// File: tb/tb_spi_lane_master_arb.sv
// tb_spi_lane_master_arb: directed frames with hand-computed pin and response expectations.
module tb_spi_lane_master_arb;
  localparam int CS_GAP = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_valid, req_ready;
  logic [3:0] req_lanes;
  logic [5:0] req_len;
  logic [63:0] req_data;
  logic rsp_valid, busy, sclk, cs_n;
  logic [0:0] rsp_id;
  logic [31:0] rsp_data;
  logic [3:0] mosi, mosi_oe, miso, miso_drv;
  logic loop;
  int checks = 0, errors = 0, cyc = 0;
  int nrise = 0, ncsfall = 0, hi_run = 0, gap_len = 0, nrsp = 0;
  logic sclk_q = 1'b0, cs_q = 1'b1;
  logic [3:0] mos_log [0:255];
  logic [3:0] oe_log [0:255];
  int b, c, r0, lat;
  bit ok;
  spi_lane_master_arb #(.NUM_REQ(2), .MAX_BYTES(4), .CLK_DIV(4), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_lanes(req_lanes), .req_len(req_len),
    .req_data(req_data), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .mosi_oe(mosi_oe), .miso(miso)
  );
  assign miso = loop ? mosi : miso_drv;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sclk && !sclk_q) begin
      if (nrise < 256) begin
        mos_log[nrise] = mosi;
        oe_log[nrise] = mosi_oe;
      end
      nrise++;
    end
    if (!cs_n && cs_q) begin
      ncsfall++;
      gap_len = hi_run;
    end
    hi_run = cs_n ? hi_run + 1 : 0;
    if (rsp_valid) nrsp++;
    sclk_q = sclk;
    cs_q = cs_n;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(output bit f);
    f = 1'b0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (|req_ready) begin
        f = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_rsp(output bit f);
    f = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      #1;
      if (rsp_valid) begin
        f = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic set_req(input int r, input logic [1:0] ln, input logic [2:0] len, input logic [31:0] d);
    req_lanes[2*r +: 2] = ln;
    req_len[3*r +: 3] = len;
    req_data[32*r +: 32] = d;
  endtask
  task automatic run(input int r, input logic [1:0] ln, input logic [2:0] len, input logic [31:0] d, output int l);
    bit f;
    int t0;
    l = -1;
    set_req(r, ln, len, d);
    req_valid[r] = 1'b1;
    wait_ready(f);
    chk("ready_seen", 32'(f), 1);
    if (!f) begin
      req_valid = '0;
      return;
    end
    chk("grant", 32'(req_ready), 32'(1 << r));
    chk("busy_pre", 32'(busy), 0);
    t0 = cyc;
    tick();
    req_valid[r] = 1'b0;
    chk("busy_post", 32'(busy), 1);
    wait_rsp(f);
    chk("rsp_seen", 32'(f), 1);
    l = cyc - t0;
  endtask
  task automatic chk_beats(input string tag, input int bb, input int n, input logic [1:0] ln, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      logic [3:0] e;
      e = ln == 2'b10 ? d[4*i +: 4] : ln == 2'b01 ? {2'b0, d[2*i +: 2]} : {3'b0, d[i]};
      chk({tag, "_mosi"}, 32'(mos_log[bb+i]), 32'(e));
      chk({tag, "_oe"}, 32'(oe_log[bb+i]), ln == 2'b10 ? 32'hF : ln == 2'b01 ? 32'h3 : 32'h1);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    req_valid = '0; req_lanes = '0; req_len = '0; req_data = '0; miso_drv = '0; loop = 1'b0;
    repeat (3) tick();
    req_valid = 2'b11;
    #1;
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_oe", 32'(mosi_oe), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", 32'(busy), 0);
    req_valid = '0;
    rst = 1'b0;
    tick();
    miso_drv = 4'b0001;
    b = nrise;
    run(0, 2'b00, 3'd1, 32'hA5, lat);
    chk("t1_id", 32'(rsp_id), 0);
    chk("t1_data", rsp_data, 32'hFF);
    tick();
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_hold", rsp_data, 32'hFF);
    chk("t1_rises", nrise - b, 8);
    chk_beats("t1", b, 8, 2'b00, 32'hA5);
    loop = 1'b1;
    b = nrise;
    run(1, 2'b10, 3'd2, 32'h3C81, lat);
    chk("t2_id", 32'(rsp_id), 1);
    chk("t2_data", rsp_data, 32'h3C81);
    tick();
    chk("t2_rises", nrise - b, 4);
    chk_beats("t2", b, 4, 2'b10, 32'h3C81);
    loop = 1'b0;
    miso_drv = 4'h6;
    set_req(0, 2'b10, 3'd1, 32'h11);
    set_req(1, 2'b10, 3'd1, 32'h22);
    req_valid = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_ready(ok);
      chk("t3_ready", 32'(ok), 1);
      chk("t3_grant", 32'(req_ready), f % 2 ? 32'd2 : 32'd1);
      wait_rsp(ok);
      chk("t3_rsp", 32'(ok), 1);
      if (f == 3) req_valid = '0;
      chk("t3_id", 32'(rsp_id), 32'(f % 2));
      chk("t3_data", rsp_data, 32'h66);
      if (f > 0) chk("t3_gap_min", 32'(gap_len >= CS_GAP), 1);
    end
    tick();
    tick();
    chk("t3_idle", 32'(busy), 0);
    b = nrise;
    c = ncsfall;
    run(0, 2'b00, 3'd0, 32'h0, lat);
    chk("t4_latency", lat, CS_GAP);
    chk("t4_id", 32'(rsp_id), 0);
    chk("t4_data", rsp_data, 0);
    tick();
    chk("t4_no_sclk", nrise - b, 0);
    chk("t4_no_cs", ncsfall - c, 0);
    set_req(0, 2'b00, 3'd1, 32'hFF);
    req_valid = 2'b01;
    wait_ready(ok);
    tick();
    req_valid = '0;
    b = nrise;
    for (int i = 0; i < 500 && nrise - b < 3; i++) tick();
    chk("t5_third_rise", nrise - b, 3);
    chk("t5_in_high", 32'(sclk), 1);
    rst = 1'b1;
    r0 = nrsp;
    tick();
    chk("t5_cs_n", 32'(cs_n), 1);
    chk("t5_sclk", 32'(sclk), 0);
    chk("t5_oe", 32'(mosi_oe), 0);
    chk("t5_mosi", 32'(mosi), 0);
    chk("t5_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (10) tick();
    chk("t5_no_rsp", nrsp - r0, 0);
    set_req(0, 2'b10, 3'd1, 32'h0);
    set_req(1, 2'b10, 3'd1, 32'h0);
    req_valid = 2'b11;
    wait_ready(ok);
    chk("t5_prio", 32'(req_ready), 1);
    tick();
    req_valid = '0;
    wait_rsp(ok);
    chk("t5_rsp_id", 32'(rsp_id), 0);
    chk("t5_rsp_data", rsp_data, 32'h66);
    tick();
    loop = 1'b1;
    b = nrise;
    run(1, 2'b11, 3'd1, 32'h5A, lat);
    chk("t6_id", 32'(rsp_id), 1);
    chk("t6_data", rsp_data, 32'h5A);
    tick();
    chk("t6_rises", nrise - b, 8);
    chk_beats("t6", b, 8, 2'b11, 32'h5A);
    b = nrise;
    run(0, 2'b10, 3'd7, 32'h12345678, lat);
    chk("clamp_id", 32'(rsp_id), 0);
    chk("clamp_data", rsp_data, 32'h12345678);
    tick();
    chk("clamp_rises", nrise - b, 8);
    chk_beats("clamp", b, 8, 2'b10, 32'h12345678);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
